// File: rtl/pattern_seq_pkg.sv
// Shared types and defaults for the pattern_sequencer block: FSM state encoding,
// default job sizing and the 4-bit hit-count type used by the recognizer.
package pattern_seq_pkg;

  localparam int MAXLEN_DEF = 28;
  localparam int LENW_DEF   = 5;

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    SHIFT,
    DRAIN,
    DONE
  } state_t;

  typedef logic [3:0] count_t;

  // Largest of three phase lengths; sizes the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seq_shifter.sv
// Loadable job shift register. MSB-first loads are left-aligned by length so the
// first bit to send always sits at the output end; one bit leaves per enable.
module seq_shifter #(
  parameter int MAXLEN = 28,
  parameter int LENW   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              en,
  input  logic [MAXLEN-1:0] load_seq,
  input  logic [LENW-1:0]   load_len,
  input  logic              load_lsb_first,
  output logic              bit_out
);

  logic [MAXLEN-1:0] sr;
  logic [MAXLEN-1:0] cur;
  logic              lsb_first;
  logic              cur_lsb;

  // A load that coincides with the first enable must already expose the new
  // job's first bit, so the output looks through the load path.
  // NOTE: every always_comb output is given a default first, so no path leaves a latch.
  always_comb begin
    cur     = sr;
    cur_lsb = lsb_first;
    if (load) begin
      cur_lsb = load_lsb_first;
      cur     = load_lsb_first ? load_seq : (load_seq << (MAXLEN - int'(load_len)));
    end
  end

  assign bit_out = cur_lsb ? cur[0] : cur[MAXLEN-1];

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr        <= '0;
      lsb_first <= 1'b0;
    end else begin
      if (load) lsb_first <= load_lsb_first;
      if (en)        sr <= cur_lsb ? (cur >> 1) : (cur << 1);
      else if (load) sr <= cur;
    end
  end

endmodule

// File: rtl/pattern_sequencer.sv
// Drives one PatternRecognizer: flushes it with zeros, serialises a job onto X,
// and reports the job's own hit count as a delta against the free-running Y.
module pattern_sequencer
  import pattern_seq_pkg::*;
#(
  parameter int MAXLEN     = MAXLEN_DEF,
  parameter int LENW       = LENW_DEF,
  parameter int GAP_CYCLES = 4,
  parameter int LAT        = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [MAXLEN-1:0] req_seq,
  input  logic [LENW-1:0]   req_len,
  input  logic              req_type,
  input  logic              req_lsb_first,
  output logic              rec_x,
  output logic              rec_type,
  input  logic [3:0]        rec_y,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [3:0]        rsp_count,
  output logic              rsp_type,
  output logic              busy
);

  localparam int CNTW = $clog2(max3(GAP_CYCLES, MAXLEN, LAT) + 1);

  state_t            state, next_state;
  logic [CNTW-1:0]   cnt, cnt_nxt;
  logic [LENW-1:0]   job_len, req_eff_len, run_len;
  count_t            baseline;
  logic              accept;
  logic              sample_base;
  logic              shift_bit;

  assign req_eff_len = (int'(req_len) > MAXLEN) ? LENW'(MAXLEN) : req_len;
  // Length that governs the GAP->SHIFT decision; in IDLE the job is not latched yet.
  assign run_len     = (state == IDLE) ? req_eff_len : job_len;

  always_comb begin
    next_state = state;
    cnt_nxt    = cnt;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          accept = 1'b1;
          if (GAP_CYCLES > 0) begin
            next_state = GAP;
            cnt_nxt    = CNTW'(GAP_CYCLES - 1);
          end else if (run_len == '0) begin
            next_state = DRAIN;
            cnt_nxt    = CNTW'(LAT - 1);
          end else begin
            next_state = SHIFT;
            cnt_nxt    = CNTW'(run_len) - CNTW'(1);
          end
        end
      end
      GAP: begin
        if (cnt == '0) begin
          if (run_len == '0) begin
            next_state = DRAIN;
            cnt_nxt    = CNTW'(LAT - 1);
          end else begin
            next_state = SHIFT;
            cnt_nxt    = CNTW'(run_len) - CNTW'(1);
          end
        end else begin
          cnt_nxt = cnt - CNTW'(1);
        end
      end
      SHIFT: begin
        if (cnt == '0) begin
          next_state = DRAIN;
          cnt_nxt    = CNTW'(LAT - 1);
        end else begin
          cnt_nxt = cnt - CNTW'(1);
        end
      end
      DRAIN: begin
        if (cnt == '0) next_state = DONE;
        else           cnt_nxt    = cnt - CNTW'(1);
      end
      DONE: begin
        if (rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Baseline is taken once the flush zeros are in, just before the first job bit lands.
  assign sample_base = (accept && (GAP_CYCLES == 0)) || ((state == GAP) && (cnt == '0));

  seq_shifter #(
    .MAXLEN(MAXLEN),
    .LENW  (LENW)
  ) u_shifter (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (accept),
    .en            (next_state == SHIFT),
    .load_seq      (req_seq),
    .load_len      (req_eff_len),
    .load_lsb_first(req_lsb_first),
    .bit_out       (shift_bit)
  );

  // Outputs are registered from next_state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      job_len   <= '0;
      baseline  <= '0;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      rec_x     <= 1'b0;
      rec_type  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_count <= '0;
      rsp_type  <= 1'b0;
    end else begin
      state     <= next_state;
      cnt       <= cnt_nxt;
      req_ready <= (next_state == IDLE);
      busy      <= (next_state != IDLE);
      rsp_valid <= (next_state == DONE);
      rec_x     <= (next_state == SHIFT) && shift_bit;
      if (accept) begin
        job_len  <= req_eff_len;
        rec_type <= req_type;
      end
      if (sample_base) baseline <= rec_y;
      if ((state == DRAIN) && (cnt == '0)) begin
        rsp_count <= rec_y - baseline;
        rsp_type  <= rec_type;
      end
    end
  end

endmodule
